cycle_sequencer: RTL
====================

Name: cycle_sequencer

Overview:
Multi-cycle control FSM for the single-issue MIPS core. It replaces free-running phase clocks with single-cycle enable strobes on the one core clock.
- Sequences fetch, decode, execute, memory and writeback.
- Handshakes with instruction and data memories that have variable latency.
- Supports run, single-step and halt control from the debug/top level.

Parameters:
ACK_TIMEOUT, 15, max cycles to wait for imem_ack/dmem_ack before FAULT; 0 disables timeout
TMR_W, 4, width of wait-cycle counter; must satisfy 2**TMR_W > ACK_TIMEOUT
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  input  1  core clock
rst_n  input  1  synchronous active-low reset
run  input  1  level; 1 = fetch continuously
step  input  1  pulse; execute exactly one instruction from IDLE
halt_req  input  1  level; stop after current instruction retires
is_load  input  1  decoder read_ram for current instruction
is_store  input  1  decoder write_mem for current instruction
wr_reg  input  1  decoder write_reg for current instruction
imem_req  output  1  instruction fetch request
imem_ack  input  1  instruction word valid this cycle
ir_load  output  1  capture fetched word into instruction register
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write qualifier
dmem_ack  input  1  data access complete this cycle
reg_we  output  1  register-file write enable, one cycle
pc_we  output  1  PC update enable, one cycle
retire  output  1  one-cycle pulse per completed instruction
busy  output  1  1 in any state except IDLE/FAULT
fault  output  1  sticky memory-timeout flag
state  output  3  current FSM state encoding (debug)

Behaviour:
- Reset:
  - Synchronous. While rst_n=0, all strobes are forced 0 combinationally.
  - On the next clk edge: state=IDLE, wait counter=0, fault=0, busy=0.
  - Reset mid-instruction abandons it with no reg_we/pc_we.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- IDLE:
  - All strobes 0.
  - Goes to FETCH when run=1 or step=1; otherwise stays.
  - halt_req=1 blocks leaving IDLE and has priority over run/step.
- FETCH:
  - imem_req=1 every cycle in state.
  - ir_load = imem_ack (combinational, same cycle).
  - On ack, go to DECODE.
- DECODE: exactly 1 cycle, then EXEC. Register reads settle here.
- EXEC:
  - Exactly 1 cycle.
  - is_load/is_store/wr_reg are sampled at the EXEC edge into internal flags held until WB.
  - If is_load|is_store, go to MEM; else go to WB.
- MEM:
  - dmem_req=1 and dmem_we=is_store flag, every cycle in state.
  - On dmem_ack, go to WB.
  - The data captured by the register file at WB is the ack-cycle value; the memory holds it until WB ends.
- WB:
  - Exactly 1 cycle.
  - pc_we=1, reg_we=wr_reg flag, retire=1.
  - Next state is FETCH if run=1 and halt_req=0; else IDLE.
- Step: a step pulse in IDLE with run=0 yields exactly one retire, then IDLE. step outside IDLE is ignored.
- Latency:
  - Minimum ALU instruction is 4 cycles (FETCH, DECODE, EXEC, WB) with 0-wait ack.
  - Load/store minimum is 5 cycles.
- Wait timer:
  - Clears on entry to FETCH/MEM and increments each cycle without ack.
  - If ACK_TIMEOUT>0 and the counter equals ACK_TIMEOUT with ack still 0, go to FAULT.
  - An ack in the same cycle the counter equals ACK_TIMEOUT counts as success.
- FAULT:
  - fault=1, all strobes 0, busy=0.
  - Exited only by reset.
- run dropping mid-instruction does not abort; the instruction completes and the FSM parks in IDLE after WB.
- Strobe exclusivity: imem_req, dmem_req and pc_we are never high in the same cycle.

Optional Feature:
CYCLE_SEQ_PERF_EN.
- Defined:
  - Adds outputs cyc_cnt[CNT_W] (increments every cycle busy=1) and ret_cnt[CNT_W] (increments on retire).
  - Adds input perf_clr, which zeroes both counters synchronously; perf_clr has priority over increment.
  - Both counters are 0 after reset and wrap modulo 2**CNT_W.
- Undefined: these ports and the counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - typedef enum logic [2:0] seq_state_t (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6).
  - Localparam defaults for ACK_TIMEOUT.
- One sub-module, seq_wait_timer: clear/increment/expire compare for the ack timeout, instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset then run=1; imem_ack and dmem_ack tied 1; ALU instruction (wr_reg=1) -> retire every 4 cycles; reg_we and pc_we each 1 cycle in WB.
- Load with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, retire at cycle 8 after FETCH entry; store -> dmem_we=1 and reg_we=0.
- run=0, single step pulse -> exactly one retire, state returns to IDLE, busy=0; a second step while busy is ignored.
- imem_ack held 0, ACK_TIMEOUT=15 -> FAULT entered after 16 FETCH cycles, fault=1 sticky; ack arriving exactly at count 15 instead proceeds to DECODE.
- halt_req asserted during EXEC with run=1 -> instruction retires, then IDLE; rst_n=0 during MEM -> no reg_we/pc_we, IDLE next edge.
- CYCLE_SEQ_PERF_EN defined: 10 ALU instructions -> ret_cnt=10, cyc_cnt=40; perf_clr together with retire -> both counters read 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control-path types for the multi-cycle MIPS core.
//   seq_state_t     : sequencer state encoding, also exported on the debug port
//   *_DEF           : default parameter values for cycle_sequencer
//   seq_busy()      : states in which an instruction is in flight
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      FAULT  = 3'd6
   } seq_state_t;

   localparam int ACK_TIMEOUT_DEF = 15;
   localparam int TMR_W_DEF       = 4;
   localparam int CNT_W_DEF       = 32;

   function automatic logic seq_busy(input seq_state_t s);
      return (s != IDLE) && (s != FAULT);
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: memory-acknowledge wait counter shared by FETCH and MEM.
//   clk, rst_n : core clock, synchronous active-low reset
//   clr        : hold counter at zero (asserted whenever not waiting on memory)
//   inc        : one more cycle passed without an acknowledge
//   expired    : counter has reached ACK_TIMEOUT (never, when ACK_TIMEOUT = 0)
// TMR_W must satisfy 2**TMR_W > ACK_TIMEOUT so the limit is reachable.
module seq_wait_timer
   import cpu_ctrl_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
   parameter int TMR_W       = TMR_W_DEF
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   logic [TMR_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + 1'b1;
   end

   // Expiry is only a comparison; the sequencer decides that an ack in the
   // same cycle still wins.
   assign expired = (ACK_TIMEOUT != 0) && (cnt == TMR_W'(ACK_TIMEOUT));

endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multi-cycle control FSM for the single-issue MIPS core.
// Produces one-cycle enable strobes on the core clock for fetch, decode,
// execute, memory and writeback, with variable-latency memory handshakes
// and run / single-step / halt control.
//   clk, rst_n          : core clock, synchronous active-low reset
//   run, step, halt_req : debug/top-level control
//   is_load, is_store,
//   wr_reg              : decoder outputs for the current instruction
//   imem_req/ack,ir_load: instruction fetch handshake and IR capture
//   dmem_req/we/ack     : data memory handshake
//   reg_we, pc_we,
//   retire              : writeback strobes
//   busy, fault, state  : status and debug state
// Build option CYCLE_SEQ_PERF_EN adds perf_clr, cyc_cnt and ret_cnt.
module cycle_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
   parameter int TMR_W       = TMR_W_DEF,
   parameter int CNT_W       = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             step,
   input  logic             halt_req,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             wr_reg,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             ir_load,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             reg_we,
   output logic             pc_we,
   output logic             retire,
   output logic             busy,
   output logic             fault,
`ifdef CYCLE_SEQ_PERF_EN
   input  logic             perf_clr,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt,
`endif
   output logic [2:0]       state
);

   seq_state_t st;
   logic       st_f;     // store flag captured at EXEC
   logic       wr_f;     // register-write flag captured at EXEC
   logic       in_wait;
   logic       ack_cur;
   logic       expired;

   // One timer serves both memory waits; it is held clear outside FETCH/MEM,
   // so every entry into either state starts counting from zero.
   assign in_wait = (st == FETCH) || (st == MEM);
   assign ack_cur = (st == FETCH) ? imem_ack : dmem_ack;

   seq_wait_timer #(
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .TMR_W       (TMR_W)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!in_wait),
      .inc     (in_wait && !ack_cur),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st   <= IDLE;
         st_f <= 1'b0;
         wr_f <= 1'b0;
      end else begin
         unique case (st)
            IDLE:   if (!halt_req && (run || step)) st <= FETCH;
            FETCH:  if (imem_ack) st <= DECODE;
                    else if (expired) st <= FAULT;
            DECODE: st <= EXEC;
            EXEC: begin
               st_f <= is_store;
               wr_f <= wr_reg;
               st   <= (is_load || is_store) ? MEM : WB;
            end
            MEM:    if (dmem_ack) st <= WB;
                    else if (expired) st <= FAULT;
            WB:     st <= (run && !halt_req) ? FETCH : IDLE;
            FAULT:  st <= FAULT;
            default: st <= FAULT;
         endcase
      end
   end

   // Strobes decode the registered state; reset squelches them immediately so
   // an abandoned instruction never writes the PC or register file.
   always_comb begin
      imem_req = 1'b0;
      ir_load  = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      reg_we   = 1'b0;
      pc_we    = 1'b0;
      retire   = 1'b0;
      if (rst_n) begin
         case (st)
            FETCH: begin
               imem_req = 1'b1;
               ir_load  = imem_ack;
            end
            MEM: begin
               dmem_req = 1'b1;
               dmem_we  = st_f;
            end
            WB: begin
               pc_we  = 1'b1;
               reg_we = wr_f;
               retire = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy  = seq_busy(st);
   assign fault = (st == FAULT);
   assign state = st;

`ifdef CYCLE_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n || perf_clr) begin
         cyc_cnt <= '0;
         ret_cnt <= '0;
      end else begin
         if (busy)   cyc_cnt <= cyc_cnt + 1'b1;
         if (retire) ret_cnt <= ret_cnt + 1'b1;
      end
   end
`else
   // CNT_W only sizes the counters; both builds share one parameter list.
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
